// File: rtl/drv_dt_pkg.sv
// rtl/drv_dt_pkg.sv - shared types and constants for the dead-time inverter driver
//
// Purpose: per-channel state encoding and the minimum dead-time count used by
//          drv_dt_ch and drv_deadtime_inv.
// Ports:   none (package).

package drv_dt_pkg;

  // Per-channel switch-pair state, fixed 3-bit encoding.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,  // both switches off, waiting for en
    ST_DEAD  = 3'd1,  // both switches off, dead-time counting
    ST_ON_T  = 3'd2,  // top switch on
    ST_ON_B  = 3'd3,  // bottom switch on
    ST_FAULT = 3'd4   // both switches off, fault latched
  } dt_state_e;

  // Shortest dead time in cycles; a dt_cfg of 0 is raised to this value.
  localparam int unsigned DT_MIN = 1;

endpackage

// File: rtl/drv_dt_ch.sv
// rtl/drv_dt_ch.sv - one switch-pair channel: state machine plus dead-time counter
//
// Purpose: drives one complementary top/bottom switch pair with break-before-make
//          dead time, enable gating and a latched fault shutdown.
// Ports:
//   clk      in   clock
//   rst      in   synchronous reset, active-high
//   en       in   enable; 0 forces the channel to IDLE unless it is in FAULT
//   dt_cfg   in   dead-time cycles, sampled on DEAD entry or reload
//   i        in   drive request: 1 = top on, 0 = bottom on
//   flt      in   fault level; forces FAULT from any state
//   flt_clr  in   fault clear pulse, honoured only while flt is low
//   o_top    out  top gate enable, registered
//   o_bot    out  bottom gate enable, registered
//   dead     out  1 while in DEAD, registered
//   flt_lat  out  1 while in FAULT, registered

module drv_dt_ch
  import drv_dt_pkg::*;
#(
  parameter int DT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [DT_W-1:0] dt_cfg,
  input  logic            i,
  input  logic            flt,
  input  logic            flt_clr,
  output logic            o_top,
  output logic            o_bot,
  output logic            dead,
  output logic            flt_lat
);

  localparam logic [DT_W-1:0] CNT_MIN = DT_W'(DT_MIN);
  localparam logic [DT_W-1:0] CNT_ONE = DT_W'(1);

  dt_state_e       state_q, state_d;
  logic [DT_W-1:0] cnt_q, cnt_d;
  logic            target_q, target_d;
  logic            o_top_q, o_top_d;
  logic            o_bot_q, o_bot_d;
  logic            dead_q, dead_d;
  logic            flt_lat_q, flt_lat_d;

  // Count loaded on every DEAD entry or restart; a zero setting still yields
  // one full dead cycle.
  logic [DT_W-1:0] dt_load;
  assign dt_load = (dt_cfg < CNT_MIN) ? CNT_MIN : dt_cfg;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    target_d = target_q;

    if (flt) begin
      state_d = ST_FAULT;
    end else if (!en && (state_q != ST_FAULT)) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // en is known to be 1 here
          state_d  = ST_DEAD;
          target_d = i;
          cnt_d    = dt_load;
        end
        ST_DEAD: begin
          // A request change restarts the full dead time toward the new side;
          // it takes precedence over an expiring count so the old target is
          // never switched on.
          if (i != target_q) begin
            target_d = i;
            cnt_d    = dt_load;
          end else if (cnt_q <= CNT_MIN) begin
            state_d = target_q ? ST_ON_T : ST_ON_B;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
        ST_ON_T: begin
          if (!i) begin
            state_d  = ST_DEAD;
            target_d = 1'b0;
            cnt_d    = dt_load;
          end
        end
        ST_ON_B: begin
          if (i) begin
            state_d  = ST_DEAD;
            target_d = 1'b1;
            cnt_d    = dt_load;
          end
        end
        ST_FAULT: begin
          // flt is known to be 0 here; the clear re-enters through DEAD so the
          // restart is always break-before-make.
          if (flt_clr) begin
            state_d  = ST_DEAD;
            target_d = i;
            cnt_d    = dt_load;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // exactly with state_q and never glitch.
  always_comb begin
    o_top_d   = (state_d == ST_ON_T);
    o_bot_d   = (state_d == ST_ON_B);
    dead_d    = (state_d == ST_DEAD);
    flt_lat_d = (state_d == ST_FAULT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      target_q  <= 1'b0;
      o_top_q   <= 1'b0;
      o_bot_q   <= 1'b0;
      dead_q    <= 1'b0;
      flt_lat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      target_q  <= target_d;
      o_top_q   <= o_top_d;
      o_bot_q   <= o_bot_d;
      dead_q    <= dead_d;
      flt_lat_q <= flt_lat_d;
    end
  end

  assign o_top   = o_top_q;
  assign o_bot   = o_bot_q;
  assign dead    = dead_q;
  assign flt_lat = flt_lat_q;

endmodule

// File: rtl/drv_deadtime_inv.sv
// rtl/drv_deadtime_inv.sv - multi-channel dead-time inverter driver top level
//
// Purpose: NCH independent complementary switch-pair drivers sharing enable,
//          dead-time setting and fault clear. o_bot carries the inverted
//          request, o_top the true request, both with break-before-make gaps.
// Ports:
//   CLK      in   clock
//   RST      in   synchronous reset, active-high
//   CELV     in   brick supply pin, no logic function
//   CELG     in   brick ground pin, no logic function
//   SUB      in   substrate pin, no logic function
//   en       in   global enable
//   dt_cfg   in   [DT_W]  dead-time cycles shared by all channels
//   i        in   [NCH]   drive request per channel
//   flt      in   [NCH]   fault level per channel
//   flt_clr  in   fault clear pulse, shared
//   o_top    out  [NCH]   top gate enables
//   o_bot    out  [NCH]   bottom gate enables
//   dead     out  [NCH]   channel in DEAD
//   flt_lat  out  [NCH]   channel in FAULT

module drv_deadtime_inv
  import drv_dt_pkg::*;
#(
  parameter int NCH  = 1,
  parameter int DT_W = 4
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CELV,
  input  logic            CELG,
  input  logic            SUB,
  input  logic            en,
  input  logic [DT_W-1:0] dt_cfg,
  input  logic [NCH-1:0]  i,
  input  logic [NCH-1:0]  flt,
  input  logic            flt_clr,
  output logic [NCH-1:0]  o_top,
  output logic [NCH-1:0]  o_bot,
  output logic [NCH-1:0]  dead,
  output logic [NCH-1:0]  flt_lat
);

  // Supply pins exist only so the brick netlists like the original inverter.
  logic unused_supply;
  assign unused_supply = CELV ^ CELG ^ SUB;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    drv_dt_ch #(
      .DT_W (DT_W)
    ) u_ch (
      .clk     (CLK),
      .rst     (RST),
      .en      (en),
      .dt_cfg  (dt_cfg),
      .i       (i[g]),
      .flt     (flt[g]),
      .flt_clr (flt_clr),
      .o_top   (o_top[g]),
      .o_bot   (o_bot[g]),
      .dead    (dead[g]),
      .flt_lat (flt_lat[g])
    );
  end

endmodule

// File: tb/tb_drv_deadtime_inv.sv
// tb/tb_drv_deadtime_inv.sv - scoreboard bench for drv_deadtime_inv

module tb_drv_deadtime_inv;

  localparam int NCH  = 2;
  localparam int DT_W = 4;

  // Expected per-channel condition after an edge.
  localparam int S_I = 0;  // idle: all outputs low
  localparam int S_D = 1;  // dead: only dead high
  localparam int S_T = 2;  // top on
  localparam int S_B = 3;  // bottom on
  localparam int S_F = 4;  // fault: only flt_lat high

  logic            clk     = 1'b0;
  logic            rst     = 1'b1;
  logic            en      = 1'b0;
  logic            flt_clr = 1'b0;
  logic            celv    = 1'b1;
  logic            celg    = 1'b0;
  logic            sub     = 1'b0;
  logic [DT_W-1:0] dt_cfg  = '0;
  logic [NCH-1:0]  i_req   = '0;
  logic [NCH-1:0]  flt     = '0;
  logic [NCH-1:0]  o_top, o_bot, dead, flt_lat;

  typedef struct {
    int         id;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   step_id  = 0;

  always #5 clk = ~clk;

  drv_deadtime_inv #(
    .NCH  (NCH),
    .DT_W (DT_W)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .CELV    (celv),
    .CELG    (celg),
    .SUB     (sub),
    .en      (en),
    .dt_cfg  (dt_cfg),
    .i       (i_req),
    .flt     (flt),
    .flt_clr (flt_clr),
    .o_top   (o_top),
    .o_bot   (o_bot),
    .dead    (dead),
    .flt_lat (flt_lat)
  );

  // Packs {o_top, o_bot, dead, flt_lat} for the two hand-written channel states.
  function automatic logic [7:0] exp_vec(input int e0, input int e1);
    logic [1:0] t, b, d, f;
    t = {e1 == S_T, e0 == S_T};
    b = {e1 == S_B, e0 == S_B};
    d = {e1 == S_D, e0 == S_D};
    f = {e1 == S_F, e0 == S_F};
    return {t, b, d, f};
  endfunction

  // Drive one input vector for n cycles; each cycle queues the outputs
  // expected right after the following rising edge.
  task automatic step(input bit r, input bit e, input int dt, input bit [1:0] ii,
                      input bit [1:0] ff, input bit c, input int e0, input int e1,
                      input int n);
    exp_t x;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst     = r;
      en      = e;
      dt_cfg  = DT_W'(dt);
      i_req   = ii;
      flt     = ff;
      flt_clr = c;
      x.id    = step_id;
      x.v     = exp_vec(e0, e1);
      q.push_back(x);
      step_id++;
    end
  endtask

  // Monitor: one output set per clock, compared against the queue head.
  initial begin
    exp_t       x;
    logic [7:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x   = q.pop_front();
        got = {o_top, o_bot, dead, flt_lat};
        n_checks++;
        if (got === x.v) n_pass++;
        else $display("FAIL outputs step %0d: got top/bot/dead/lat=%b required %b", x.id, got, x.v);
        n_checks++;
        if ((o_top & o_bot) === '0) n_pass++;
        else $display("FAIL overlap step %0d: o_top=%b o_bot=%b required no common bit", x.id, o_top, o_bot);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // power-up: reset held, then dead time of 3 toward bottom
    step(1'b1, 1'b1, 3, 2'b00, 2'b00, 1'b0, S_I, S_I, 2);
    step(1'b0, 1'b1, 3, 2'b00, 2'b00, 1'b0, S_D, S_D, 3);
    step(1'b0, 1'b1, 3, 2'b00, 2'b00, 1'b0, S_B, S_B, 2);
    // ch0 bottom -> top with dead time 3, ch1 stays bottom
    step(1'b0, 1'b1, 3, 2'b01, 2'b00, 1'b0, S_D, S_B, 3);
    step(1'b0, 1'b1, 3, 2'b01, 2'b00, 1'b0, S_T, S_B, 2);
    // dt=5, request drops then returns two cycles into DEAD: full reload;
    // dt_cfg lowered during the count must not shorten it
    step(1'b0, 1'b1, 5, 2'b00, 2'b00, 1'b0, S_D, S_B, 2);
    step(1'b0, 1'b1, 5, 2'b01, 2'b00, 1'b0, S_D, S_B, 1);
    step(1'b0, 1'b1, 1, 2'b01, 2'b00, 1'b0, S_D, S_B, 4);
    step(1'b0, 1'b1, 1, 2'b01, 2'b00, 1'b0, S_T, S_B, 1);
    // one-cycle fault on ch0: latched, ch1 untouched, then cleared
    step(1'b0, 1'b1, 3, 2'b01, 2'b01, 1'b0, S_F, S_B, 1);
    step(1'b0, 1'b1, 3, 2'b01, 2'b00, 1'b0, S_F, S_B, 3);
    step(1'b0, 1'b1, 3, 2'b01, 2'b00, 1'b1, S_D, S_B, 1);
    step(1'b0, 1'b1, 3, 2'b01, 2'b00, 1'b0, S_D, S_B, 2);
    step(1'b0, 1'b1, 3, 2'b01, 2'b00, 1'b0, S_T, S_B, 1);
    // fault on ch1, ch0 keeps driving top
    step(1'b0, 1'b1, 3, 2'b01, 2'b10, 1'b0, S_T, S_F, 2);
    step(1'b0, 1'b1, 3, 2'b01, 2'b00, 1'b1, S_T, S_D, 3);
    step(1'b0, 1'b1, 3, 2'b01, 2'b00, 1'b0, S_T, S_B, 1);
    // clear ignored while flt high, en=0 keeps FAULT, reset clears it
    step(1'b0, 1'b1, 3, 2'b01, 2'b01, 1'b0, S_F, S_B, 1);
    step(1'b0, 1'b1, 3, 2'b01, 2'b01, 1'b1, S_F, S_B, 2);
    step(1'b0, 1'b0, 3, 2'b01, 2'b00, 1'b0, S_F, S_I, 2);
    step(1'b1, 1'b0, 3, 2'b01, 2'b00, 1'b0, S_I, S_I, 1);
    // dt_cfg=0 behaves as a single dead cycle, both directions
    step(1'b0, 1'b1, 0, 2'b01, 2'b00, 1'b0, S_D, S_D, 1);
    step(1'b0, 1'b1, 0, 2'b01, 2'b00, 1'b0, S_T, S_B, 1);
    step(1'b0, 1'b1, 0, 2'b10, 2'b00, 1'b0, S_D, S_D, 1);
    step(1'b0, 1'b1, 0, 2'b10, 2'b00, 1'b0, S_B, S_T, 2);
    // reset in the middle of a dead time
    step(1'b0, 1'b1, 7, 2'b01, 2'b00, 1'b0, S_D, S_D, 3);
    step(1'b1, 1'b1, 7, 2'b01, 2'b00, 1'b0, S_I, S_I, 1);
    // longest dead time
    step(1'b0, 1'b1, 15, 2'b10, 2'b00, 1'b0, S_D, S_D, 15);
    step(1'b0, 1'b1, 15, 2'b10, 2'b00, 1'b0, S_B, S_T, 1);
    // en=0 drops driving channels to IDLE
    step(1'b0, 1'b0, 15, 2'b10, 2'b00, 1'b0, S_I, S_I, 2);

    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
    if (q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
